// File: rtl/adc_scan_ctrl.sv
// Scan sequencer in front of the SPI ADC interface: a sample-rate timer
// kicks off a scan of the enabled channels (lowest first), each result is
// stored in an 8-entry register file and strobed out, and scan overruns and
// stuck conversions are flagged.
module adc_scan_ctrl #(
    parameter int unsigned SAMPLE_DIV = 5000,
    parameter int unsigned TIMEOUT    = 4095
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic [7:0]  ch_mask,
    output logic        start_cnv,
    output logic [2:0]  adc_channel,
    input  logic [11:0] adc_result,
    input  logic        cnv_complete,
    output logic        sample_valid,
    output logic [2:0]  sample_ch,
    output logic [11:0] sample_data,
    input  logic [2:0]  rd_ch,
    output logic [11:0] rd_data,
    output logic        busy,
    output logic        scan_done,
    output logic        overrun,
    output logic        timeout_err,
    input  logic        clr_flags
);

    localparam int unsigned TW = (SAMPLE_DIV > 2) ? $clog2(SAMPLE_DIV) : 1;
    localparam int unsigned OW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {IDLE, SELECT, ISSUE, WAIT, STORE} state_t;

    state_t        state, state_nx;
    logic [TW-1:0] tick_cnt;
    logic          tick;
    logic [7:0]    pending;
    logic [2:0]    cur_ch;
    logic [2:0]    low_ch;
    logic [OW-1:0] to_cnt;
    logic          wait_armed;
    logic          cnv_seen;
    logic          to_expire;
    logic          last_ch;
    logic [11:0]   regfile [8];

    assign tick        = en && (tick_cnt == TW'(SAMPLE_DIV - 1));
    assign adc_channel = cur_ch;
    // The first WAIT cycle ignores cnv_complete so a stale level cannot end the wait.
    assign cnv_seen    = (state == WAIT) && wait_armed && cnv_complete;
    // A completion seen in the same cycle as the timeout takes priority.
    assign to_expire   = (state == WAIT) && (to_cnt == OW'(TIMEOUT - 1)) && !cnv_seen;
    assign last_ch     = (pending == '0) || !en;

    // Sample-rate timer: free-runs while enabled, held at zero otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)             tick_cnt <= '0;
        else if (!en || tick)   tick_cnt <= '0;
        else                    tick_cnt <= tick_cnt + 1'b1;
    end

    // Lowest pending channel, picked in SELECT.
    always_comb begin
        low_ch = '0;
        for (int unsigned i = 8; i > 0; i--) begin
            if (pending[i-1]) low_ch = 3'(i - 1);
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    // Next-state logic.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (tick && ch_mask != '0) state_nx = SELECT;
            SELECT:  state_nx = ISSUE;
            ISSUE:   state_nx = WAIT;
            WAIT: begin
                if (cnv_seen)       state_nx = STORE;
                else if (to_expire) state_nx = last_ch ? IDLE : SELECT;
            end
            STORE:   state_nx = last_ch ? IDLE : SELECT;
            default: state_nx = IDLE;
        endcase
    end

    // Scan bookkeeping: channel snapshot, current channel, timeout counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending    <= '0;
            cur_ch     <= '0;
            to_cnt     <= '0;
            wait_armed <= 1'b0;
        end else begin
            case (state)
                IDLE: if (tick && ch_mask != '0) pending <= ch_mask;
                SELECT: begin
                    cur_ch          <= low_ch;
                    pending[low_ch] <= 1'b0;
                end
                ISSUE: begin
                    to_cnt     <= '0;
                    wait_armed <= 1'b0;
                end
                WAIT: begin
                    to_cnt     <= to_cnt + 1'b1;
                    wait_armed <= 1'b1;
                    if (to_expire && last_ch) pending <= '0;
                end
                STORE: if (last_ch) pending <= '0;
                default: ;
            endcase
        end
    end

    // Result register file, written once per completed conversion.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < 8; i++) regfile[i] <= '0;
        end else if (state == STORE) begin
            regfile[cur_ch] <= adc_result;
        end
    end

    // Sticky error flags; a set event beats a simultaneous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overrun     <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            if (tick && state != IDLE) overrun <= 1'b1;
            else if (clr_flags)        overrun <= 1'b0;
            if (to_expire)             timeout_err <= 1'b1;
            else if (clr_flags)        timeout_err <= 1'b0;
        end
    end

    // Outputs decoded from state; rd_data bypasses the write in STORE.
    always_comb begin
        start_cnv    = (state == ISSUE);
        busy         = (state != IDLE);
        sample_valid = (state == STORE);
        sample_ch    = (state == STORE) ? cur_ch : '0;
        sample_data  = (state == STORE) ? adc_result : '0;
        scan_done    = ((state == STORE) || to_expire) && last_ch;
        rd_data      = regfile[rd_ch];
        if (state == STORE && rd_ch == cur_ch) rd_data = adc_result;
    end

endmodule

// File: tb/tb_adc_scan_ctrl.sv
// Self-checking bench for adc_scan_ctrl: table-driven scans, directed
// multi-cycle sequences, and a randomized phase against a scan-level model.
module tb_adc_scan_ctrl;

    logic        clk = 1'b0;
    logic        rst_n, en, cnv_complete, clr_flags;
    logic [7:0]  ch_mask;
    logic        start_cnv, sample_valid, busy, scan_done, overrun, timeout_err;
    logic [2:0]  adc_channel, sample_ch, rd_ch;
    logic [11:0] adc_result, sample_data, rd_data;

    adc_scan_ctrl #(.SAMPLE_DIV(64), .TIMEOUT(100)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .ch_mask(ch_mask),
        .start_cnv(start_cnv), .adc_channel(adc_channel),
        .adc_result(adc_result), .cnv_complete(cnv_complete),
        .sample_valid(sample_valid), .sample_ch(sample_ch), .sample_data(sample_data),
        .rd_ch(rd_ch), .rd_data(rd_data), .busy(busy), .scan_done(scan_done),
        .overrun(overrun), .timeout_err(timeout_err), .clr_flags(clr_flags)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          failures = 0;
    int          k = 0;
    int          adc_delay = 20;      // 0 = conversion never completes
    int          cd = 0;
    logic [2:0]  cv_ch;
    logic [11:0] conv_val = '0;
    logic [11:0] adc_val [8];
    logic [11:0] rf [8];
    logic [11:0] mon_exp;
    bit          rd_rand = 0;

    typedef struct {
        logic [7:0]  mask;
        int          delay;
        logic [11:0] base;
        int          exp_n;
        int          exp_first;
        int          exp_last;
    } vec_t;
    vec_t vec [5];

    int n, first, last, prev, found, b, done, seen_start, ok;
    int pending_first, scans_exp, scans_got;
    int exp_q [$];
    int iss_q [$];
    int e_ch;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic adv();
        @(posedge clk);
        #1;
        k++;
        if (rd_rand) rd_ch = 3'($urandom_range(0, 7));
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    // Disable scanning, wait for idle, clear flags; leaves k=0 at posedge+1.
    task automatic quiesce();
        int cnt;
        en = 0;
        cnt = 0;
        smp();
        while (busy && cnt < 400) begin
            adv(); smp(); cnt++;
        end
        chk("quiesce_idle", busy, 0);
        adv();
        clr_flags = 1;
        adv();
        clr_flags = 0;
        k = 0;
    endtask

    // ADC interface model: start_cnv clears cnv_complete, result after adc_delay cycles.
    initial begin
        cnv_complete = 0;
        adc_result   = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                cd = 0;
                cnv_complete = 0;
            end else if (start_cnv) begin
                cnv_complete = 0;
                cv_ch = adc_channel;
                cd = adc_delay;
            end else if (cd > 0) begin
                cd--;
                if (cd == 0) begin
                    adc_result   = adc_val[cv_ch];
                    conv_val     = adc_val[cv_ch];
                    cnv_complete = 1;
                end
            end
        end
    end

    // Register-file shadow: every cycle rd_data must match the stored results.
    initial begin
        for (int i = 0; i < 8; i++) rf[i] = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                for (int i = 0; i < 8; i++) rf[i] = '0;
            end else begin
                mon_exp = rf[rd_ch];
                if (sample_valid && sample_ch == rd_ch) mon_exp = conv_val;
                chk("rd_data", rd_data, mon_exp);
                if (sample_valid) rf[sample_ch] = conv_val;
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 0; en = 0; ch_mask = '0; rd_ch = '0; clr_flags = 0;
        for (int i = 0; i < 8; i++) adc_val[i] = '0;
        vec[0] = '{mask: 8'h01, delay: 20, base: 12'hABC, exp_n: 1, exp_first: 0, exp_last: 0};
        vec[1] = '{mask: 8'hA5, delay: 20, base: 12'h100, exp_n: 4, exp_first: 0, exp_last: 7};
        vec[2] = '{mask: 8'h80, delay: 5,  base: 12'h3F0, exp_n: 1, exp_first: 7, exp_last: 7};
        vec[3] = '{mask: 8'hFF, delay: 2,  base: 12'h800, exp_n: 8, exp_first: 0, exp_last: 7};
        vec[4] = '{mask: 8'h12, delay: 50, base: 12'h020, exp_n: 2, exp_first: 1, exp_last: 4};

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_start_cnv", start_cnv, 0);
        chk("rst_busy", busy, 0);
        chk("rst_sample_valid", sample_valid, 0);
        chk("rst_scan_done", scan_done, 0);
        chk("rst_overrun", overrun, 0);
        chk("rst_timeout_err", timeout_err, 0);
        chk("rst_adc_channel", adc_channel, 0);
        chk("rst_sample_ch", sample_ch, 0);
        chk("rst_sample_data", sample_data, 0);
        for (int i = 0; i < 8; i++) begin
            rd_ch = 3'(i);
            #1;
            chk("rst_regfile", rd_data, 0);
        end
        rst_n = 1;
        adv();
        rd_rand = 1;

        // Table-driven single scans
        for (int e = 0; e < 5; e++) begin
            quiesce();
            ch_mask = vec[e].mask;
            adc_delay = vec[e].delay;
            for (int i = 0; i < 8; i++) adc_val[i] = vec[e].base + 12'(i);
            en = 1;
            n = 0; first = -1; last = -1; prev = -1; done = 0; seen_start = 0;
            while (!done && k < 2000) begin
                smp();
                if (start_cnv && !seen_start) begin
                    chk("tbl_first_issue_cycle", k, 65);
                    chk("tbl_first_issue_ch", adc_channel, vec[e].exp_first);
                    seen_start = 1;
                end
                if (sample_valid) begin
                    if (n == 0) chk("tbl_first_sample_cycle", k, 66 + vec[e].delay);
                    chk("tbl_sample_data", sample_data, vec[e].base + 12'(sample_ch));
                    ok = (vec[e].mask[sample_ch] && int'(sample_ch) > prev) ? 1 : 0;
                    chk("tbl_sample_order", ok, 1);
                    prev = int'(sample_ch);
                    if (first < 0) first = int'(sample_ch);
                    last = int'(sample_ch);
                    n++;
                end
                if (scan_done) begin
                    done = 1;
                    chk("tbl_done_with_last_sample", sample_valid, 1);
                end
                adv();
            end
            chk("tbl_scan_done_seen", done, 1);
            chk("tbl_sample_count", n, vec[e].exp_n);
            chk("tbl_first_ch", first, vec[e].exp_first);
            chk("tbl_last_ch", last, vec[e].exp_last);
            smp();
            chk("tbl_busy_after_done", busy, 0);
            adv();
        end

        // Overrun: ticks every 64 cycles, conversions of 80 cycles
        quiesce();
        ch_mask = 8'h01; adc_delay = 80; adc_val[0] = 12'h5A5; en = 1;
        while (k < 260) begin
            smp();
            if (k == 126) chk("ovr_before_drop", overrun, 0);
            if (k == 128) chk("ovr_after_drop", overrun, 1);
            if (k == 131) chk("ovr_cleared", overrun, 0);
            if (k == 146) chk("ovr_first_sample", sample_valid, 1);
            if (k == 254) chk("ovr_still_clear", overrun, 0);
            if (k == 256) chk("ovr_set_wins_clear", overrun, 1);
            adv();
            clr_flags = (k == 130 || k == 255);
        end
        clr_flags = 0;

        // Timeout: conversion never completes
        quiesce();
        ch_mask = 8'h03; adc_delay = 0; rd_rand = 0; rd_ch = 3'd0; en = 1;
        n = 0;
        while (k < 270) begin
            smp();
            if (sample_valid) n++;
            if (k == 65) begin
                chk("to_issue0", start_cnv, 1);
                chk("to_issue0_ch", adc_channel, 0);
            end
            if (k == 120) chk("to_ch_stable_in_wait", adc_channel, 0);
            if (k == 165) begin
                chk("to_flag_not_yet", timeout_err, 0);
                chk("to_no_done_mid", scan_done, 0);
            end
            if (k == 166) chk("to_flag_set", timeout_err, 1);
            if (k == 167) begin
                chk("to_issue1", start_cnv, 1);
                chk("to_issue1_ch", adc_channel, 1);
            end
            if (k == 267) chk("to_done_after_ch1", scan_done, 1);
            adv();
        end
        chk("to_no_samples", n, 0);
        rd_rand = 1;

        // Randomized scans against a scan-level model
        quiesce();
        adc_delay = 3; en = 1;
        pending_first = -1; scans_exp = 0; scans_got = 0;
        exp_q.delete(); iss_q.delete();
        while (k < 1342) begin
            if ($urandom_range(0, 7) == 0)
                ch_mask = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
            smp();
            if (k % 64 == 63) begin
                for (int i = 0; i < 8; i++) adc_val[i] = 12'($urandom);
                adc_delay = int'($urandom_range(2, 4));
                if (ch_mask != 8'h00) begin
                    for (int i = 0; i < 8; i++) begin
                        if (ch_mask[i]) begin
                            exp_q.push_back(i);
                            iss_q.push_back(i);
                        end
                    end
                    pending_first = k + 2;
                    scans_exp++;
                end
            end
            if (start_cnv) begin
                if (iss_q.size() == 0) chk("rnd_unexpected_issue", 1, 0);
                else chk("rnd_issue_ch", adc_channel, iss_q.pop_front());
                if (pending_first >= 0) begin
                    chk("rnd_issue_latency", k, pending_first);
                    pending_first = -1;
                end
            end
            if (sample_valid) begin
                if (exp_q.size() == 0) chk("rnd_unexpected_sample", 1, 0);
                else begin
                    e_ch = exp_q.pop_front();
                    chk("rnd_sample_ch", sample_ch, e_ch);
                    chk("rnd_sample_data", sample_data, adc_val[e_ch]);
                end
            end
            if (scan_done) scans_got++;
            adv();
        end
        chk("rnd_samples_left", exp_q.size(), 0);
        chk("rnd_scan_count", scans_got, scans_exp);
        chk("rnd_no_overrun", overrun, 0);
        chk("rnd_no_timeout", timeout_err, 0);

        // en dropped during channel 2 conversion
        quiesce();
        ch_mask = 8'hFF; adc_delay = 20;
        for (int i = 0; i < 8; i++) adc_val[i] = 12'h300 + 12'(i);
        en = 1;
        found = 0;
        while (!found && k < 400) begin
            smp();
            if (start_cnv && adc_channel == 3'd2) found = 1;
            adv();
        end
        chk("endrop_ch2_issued", found, 1);
        repeat (5) adv();
        en = 0;
        found = 0;
        while (!found && k < 600) begin
            smp();
            if (sample_valid) begin
                found = 1;
                chk("endrop_store_ch", sample_ch, 2);
                chk("endrop_store_data", sample_data, 12'h302);
                chk("endrop_scan_done", scan_done, 1);
            end
            adv();
        end
        chk("endrop_stored", found, 1);
        smp();
        chk("endrop_busy_fall", busy, 0);
        n = 0;
        repeat (200) begin
            adv(); smp();
            if (start_cnv) n++;
        end
        chk("endrop_no_issue", n, 0);

        // Empty mask: ticks ignored, no flag
        adv();
        clr_flags = 1;
        adv();
        clr_flags = 0; ch_mask = 8'h00; en = 1; k = 0;
        n = 0; b = 0;
        while (k < 200) begin
            smp();
            if (start_cnv) n++;
            if (busy) b++;
            adv();
        end
        chk("mask0_no_issue", n, 0);
        chk("mask0_no_busy", b, 0);
        chk("mask0_no_overrun", overrun, 0);

        // Asynchronous reset while start_cnv is high
        quiesce();
        ch_mask = 8'h01; adc_delay = 80; adc_val[0] = 12'h777; en = 1;
        while (k < 193) adv();
        smp();
        chk("arst_pre_issue", start_cnv, 1);
        chk("arst_pre_overrun", overrun, 1);
        #1 rst_n = 0;
        #1;
        chk("arst_start_cnv", start_cnv, 0);
        chk("arst_busy", busy, 0);
        chk("arst_overrun", overrun, 0);
        chk("arst_timeout_err", timeout_err, 0);
        chk("arst_adc_channel", adc_channel, 0);
        chk("arst_sample_valid", sample_valid, 0);
        rd_rand = 0;
        for (int i = 0; i < 8; i++) begin
            rd_ch = 3'(i);
            #1;
            chk("arst_regfile", rd_data, 0);
        end
        en = 0;
        @(posedge clk);
        #1 rst_n = 1;
        repeat (2) @(posedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/adc_scan_ctrl.md
Name: adc_scan_ctrl

Overview:
- Sequencer that sits in front of the SPI ADC interface and drives its channel/start_cnv handshake.
- A programmable sample-rate timer starts a scan of all enabled channels, lowest channel first.
- Each result goes into an 8-entry result register file and is also emitted as a one-cycle strobe for the effects datapath.
- Also detects scan overruns and conversions that never complete.

Parameters:
SAMPLE_DIV, 5000, clk cycles per scan tick (>=2; 10 kHz scan rate at 50 MHz)
TIMEOUT, 4095, max clk cycles to wait for cnv_complete before aborting a conversion

Ports:
clk  in  1  system clock
rst_n  in  1  reset, asynchronous, active-low
en  in  1  scan enable; timer runs only while high
ch_mask  in  8  channel enable mask, bit n = ADC channel n
start_cnv  out  1  one-cycle conversion request to ADC interface
adc_channel  out  3  channel select to ADC interface
adc_result  in  12  conversion result from ADC interface
cnv_complete  in  1  level from ADC interface; cleared by start_cnv, set when result valid
sample_valid  out  1  one-cycle strobe, new sample stored
sample_ch  out  3  channel of the current sample_valid
sample_data  out  12  data of the current sample_valid
rd_ch  in  3  register-file read address
rd_data  out  12  combinational read of result register rd_ch
busy  out  1  high whenever FSM is not IDLE
scan_done  out  1  one-cycle strobe after the last channel of a scan
overrun  out  1  sticky: a tick arrived while busy
timeout_err  out  1  sticky: a conversion hit TIMEOUT
clr_flags  in  1  clears overrun and timeout_err

Behaviour:
- Reset values:
  - all outputs 0, all 8 result registers 0.
  - tick counter 0, pending 0, FSM in IDLE.
- Tick counter:
  - counts 0..SAMPLE_DIV-1 while en=1; tick is asserted in the cycle the count equals SAMPLE_DIV-1, then the count wraps to 0.
  - while en=0 the counter is held at 0 and no ticks occur.
- FSM states: IDLE, SELECT, ISSUE, WAIT, STORE.
  - IDLE:
    - on tick with ch_mask!=0: latch pending<=ch_mask, go to SELECT.
    - tick with ch_mask==0 is ignored; no flag is set.
  - SELECT: cur_ch<=index of the lowest set bit of pending; clear that bit; adc_channel<=cur_ch; go to ISSUE.
  - ISSUE: start_cnv=1 for exactly this cycle; clear the timeout counter and the WAIT guard; go to WAIT.
  - WAIT:
    - cnv_complete is ignored in the first WAIT cycle (guard against a stale level).
    - from the second cycle on, cnv_complete=1 sends the FSM to STORE.
    - the timeout counter increments each WAIT cycle; at TIMEOUT: set timeout_err and skip to the next-channel decision without writing.
  - STORE:
    - write regfile[cur_ch]<=adc_result; sample_valid=1; sample_ch=cur_ch; sample_data=adc_result.
    - the new value is visible on rd_data in the same cycle if rd_ch=cur_ch.
- Next-channel decision (after STORE or timeout):
  - pending!=0 and en=1 -> SELECT.
  - otherwise: scan_done=1 for one cycle, pending<=0, go to IDLE.
- Latency:
  - tick in cycle T -> start_cnv in cycle T+2.
  - cnv_complete first seen high in cycle C (C > ISSUE+1) -> sample_valid in cycle C+1.
- adc_channel holds its value from SELECT until the next SELECT and never changes during WAIT.
- ch_mask changes during a scan do not affect that scan (snapshot); they apply from the next tick.
- en deasserted mid-scan: the in-flight conversion completes and is stored, no further channels are issued, and scan_done still pulses.
- Tick while busy: the tick is dropped and overrun<=1.
- clr_flags clears both sticky flags; if a set event occurs in the same cycle, the set wins.
- Asynchronous reset mid-scan: everything returns to reset values immediately; start_cnv drops.

Test Plan:
- SAMPLE_DIV=64, ch_mask=8'h01, ADC model returns 12'hABC after 1100 cycles -> start_cnv with adc_channel=0 at T+2; sample_valid with sample_ch=0, sample_data=12'hABC; scan_done; rd_ch=0 reads 12'hABC.
- ch_mask=8'hA5, model returns 12'h100+channel, SAMPLE_DIV=8000 -> sample_ch order 0,2,5,7 with data 12'h100/102/105/107; single scan_done after channel 7; rd_data matches per channel.
- SAMPLE_DIV=64 with 1100-cycle conversions -> overrun=1 after the first dropped tick; clr_flags pulse -> 0; clr_flags asserted in the same cycle as a dropped tick -> overrun stays 1.
- Model never asserts cnv_complete, TIMEOUT=100, ch_mask=8'h03 -> timeout_err=1 exactly 100 WAIT cycles after channel 0 ISSUE; channel 1 is issued next; regfile[0] unchanged.
- ch_mask=8'hFF, en dropped during channel 2 conversion -> channel 2 stored, no start_cnv for channel 3, scan_done pulses, busy falls; ch_mask=8'h00 with en=1 -> no start_cnv over 3 ticks.
- Assert rst_n=0 during WAIT -> start_cnv, busy, and flags 0 immediately; all regfile entries read 0.
